yc_memmap_req_sched: RTL and testbench

// Shares one NoC memory-map target among NREQ local requesters. A round-robin

---
 rtl/yc_noc_defs.sv | 68 ++++++
 rtl/yc_memmap_req_sched_rr_arbiter.sv | 27 ++
 rtl/yc_memmap_req_sched.sv | 151 +++++++++++++++
 tb/tb_yc_memmap_req_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/yc_noc_defs.sv
// Shared NoC definitions: flit layout, opcodes, virtual channels, and the
// memmap request-scheduler state type.
package yc_noc_defs;

  localparam logic [1:0] VC_REQ = 2'd0;
  localparam logic [1:0] VC_RSP = 2'd1;

  localparam logic [3:0] OP_WRITE     = 4'h1;
  localparam logic [3:0] OP_READ_REQ  = 4'h2;
  localparam logic [3:0] OP_READ_RESP = 4'h3;

  localparam logic [15:0] RD_ERR_DATA = 16'hDEAD;

  typedef struct packed {
    logic [1:0]  vc;
    logic [3:0]  opc;
    logic [7:0]  len;
    logic [3:0]  src_x;
    logic [3:0]  src_y;
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic [31:0] pay;
  } flit_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} sched_st_t;

  function automatic flit_t build_flit(input logic [1:0] vc, input logic [3:0] opc,
                                       input logic [7:0] len,
                                       input logic [3:0] src_x, input logic [3:0] src_y,
                                       input logic [3:0] dst_x, input logic [3:0] dst_y,
                                       input logic [31:0] pay);
    flit_t f;
    f.vc    = vc;
    f.opc   = opc;
    f.len   = len;
    f.src_x = src_x;
    f.src_y = src_y;
    f.dst_x = dst_x;
    f.dst_y = dst_y;
    f.pay   = pay;
    return f;
  endfunction

  function automatic logic [3:0] get_opc(input flit_t f);
    return f.opc;
  endfunction

  function automatic logic [3:0] get_src_x(input flit_t f);
    return f.src_x;
  endfunction

  function automatic logic [3:0] get_src_y(input flit_t f);
    return f.src_y;
  endfunction

  function automatic logic [3:0] get_dst_x(input flit_t f);
    return f.dst_x;
  endfunction

  function automatic logic [3:0] get_dst_y(input flit_t f);
    return f.dst_y;
  endfunction

  function automatic logic [31:0] get_pay(input flit_t f);
    return f.pay;
  endfunction

endpackage

// File: rtl/yc_memmap_req_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping), returning both a one-hot grant and its index.
module yc_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_any && req[(int'(ptr) + i) % N]) begin
        gnt_any                      = 1'b1;
        gnt[(int'(ptr) + i) % N]     = 1'b1;
        gnt_idx                      = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/yc_memmap_req_sched.sv
// Shares one NoC memmap target among NREQ local requesters, keeping a single
// outstanding transaction and routing the read response or timeout back.
module yc_memmap_req_sched
  import yc_noc_defs::*;
#(
  parameter int NREQ    = 4,
  parameter int SELF_X  = 0,
  parameter int SELF_Y  = 0,
  parameter int DST_X   = 1,
  parameter int DST_Y   = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*16-1:0]   req_addr,
  input  logic [NREQ*16-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 tx_valid,
  output flit_t                tx_flit,
  input  logic                 tx_ready,
  input  logic                 rx_valid,
  input  flit_t                rx_flit,
  output logic                 rx_ready,
  output logic [15:0]          stale_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] SX = 4'(SELF_X);
  localparam logic [3:0] SY = 4'(SELF_Y);
  localparam logic [3:0] DX = 4'(DST_X);
  localparam logic [3:0] DY = 4'(DST_Y);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  sched_st_t         st;
  logic [IW-1:0]     rr_ptr;
  logic [7:0]        timer;
  logic [IW-1:0]     cur_idx;
  logic              cur_we;
  logic [15:0]       cur_addr;

  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              sel_we;
  logic [15:0]       sel_addr;
  logic [15:0]       sel_wdata;
  logic              rx_match;
  logic              rx_accept;
  logic              unused_rx;

  yc_rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign sel_we    = req_we[gnt_idx];
  assign sel_addr  = req_addr[int'(gnt_idx)*16 +: 16];
  assign sel_wdata = req_wdata[int'(gnt_idx)*16 +: 16];

  // Grants are only offered from IDLE, so RESP never overlaps a new accept.
  assign req_ready = (!rst && st == IDLE) ? gnt : '0;
  assign rx_ready  = !rst;

  assign rx_match = rx_valid
                 && get_opc(rx_flit) == OP_READ_RESP
                 && get_dst_x(rx_flit) == SX && get_dst_y(rx_flit) == SY
                 && get_src_x(rx_flit) == DX && get_src_y(rx_flit) == DY
                 && rx_flit.pay[31:16] == cur_addr;
  assign rx_accept = (st == WAIT_RSP) && rx_match;

  assign unused_rx = ^{rx_flit.vc, rx_flit.len};

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      rr_ptr    <= '0;
      timer     <= '0;
      cur_idx   <= '0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      tx_valid  <= 1'b0;
      tx_flit   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      stale_cnt <= '0;
    end else begin
      rsp_valid <= '0;

      // Every flit we see is consumed; anything not completing the read is stale.
      if (rx_valid && !rx_accept && stale_cnt != 16'hFFFF)
        stale_cnt <= stale_cnt + 16'd1;

      case (st)
        IDLE: begin
          if (gnt_any) begin
            cur_idx  <= gnt_idx;
            cur_we   <= sel_we;
            cur_addr <= sel_addr;
            tx_flit  <= build_flit(VC_REQ, sel_we ? OP_WRITE : OP_READ_REQ, 8'd1,
                                   SX, SY, DX, DY,
                                   {sel_addr, sel_we ? sel_wdata : 16'h0000});
            tx_valid <= 1'b1;
            rr_ptr   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            st       <= ISSUE;
          end
        end
        ISSUE: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (cur_we) begin
              rsp_rdata <= 16'h0000;
              rsp_err   <= 1'b0;
              rsp_valid <= ONE_HOT0 << cur_idx;
              st        <= RESP;
            end else begin
              timer <= '0;
              st    <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          timer <= timer + 8'd1;
          if (rx_match) begin
            rsp_rdata <= rx_flit.pay[15:0];
            rsp_err   <= 1'b0;
            rsp_valid <= ONE_HOT0 << cur_idx;
            st        <= RESP;
          end else if (timer == TMO_LAST) begin
            rsp_rdata <= RD_ERR_DATA;
            rsp_err   <= 1'b1;
            rsp_valid <= ONE_HOT0 << cur_idx;
            st        <= RESP;
          end
        end
        RESP:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yc_memmap_req_sched.sv
// Bench for yc_memmap_req_sched: directed scenarios followed by random
// transactions, checked against a transaction-level model of the scheduler.
module tb_yc_memmap_req_sched;
  import yc_noc_defs::*;

  localparam int N  = 4;
  localparam int TO = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*16-1:0] req_addr;
  logic [N*16-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [15:0]     rsp_rdata;
  logic            rsp_err;
  logic            tx_valid;
  flit_t           tx_flit;
  logic            tx_ready;
  logic            rx_valid;
  flit_t           rx_flit;
  logic            rx_ready;
  logic [15:0]     stale_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;
  int m_stale  = 0;

  always #5 clk = ~clk;

  yc_memmap_req_sched #(
    .NREQ(N), .SELF_X(0), .SELF_Y(0), .DST_X(1), .DST_Y(0), .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .tx_valid  (tx_valid),
    .tx_flit   (tx_flit),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_flit   (rx_flit),
    .rx_ready  (rx_ready),
    .stale_cnt (stale_cnt)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requesting index at or after the pointer.
  function automatic int exp_grant(input logic [N-1:0] mask, input int ptr);
    for (int i = 0; i < N; i++)
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic flit_t ref_flit(input logic [1:0] vc, input logic [3:0] opc,
                                     input logic [3:0] sx, input logic [3:0] sy,
                                     input logic [3:0] dx, input logic [3:0] dy,
                                     input logic [31:0] pay);
    flit_t f;
    f       = '0;
    f.vc    = vc;
    f.opc   = opc;
    f.len   = 8'd1;
    f.src_x = sx;
    f.src_y = sy;
    f.dst_x = dx;
    f.dst_y = dy;
    f.pay   = pay;
    return f;
  endfunction

  task automatic apply_stimulus(input int p, input logic we, input logic [15:0] a, input logic [15:0] w);
    req_we[p]          = we;
    req_addr[p*16+:16]  = a;
    req_wdata[p*16+:16] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge clk); #1;
    check_output("rst.req_ready", 64'(req_ready), 64'(0));
    check_output("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    check_output("rst.rsp_rdata", 64'(rsp_rdata), 64'(0));
    check_output("rst.rsp_err",   64'(rsp_err),   64'(0));
    check_output("rst.tx_valid",  64'(tx_valid),  64'(0));
    check_output("rst.tx_flit",   64'(tx_flit),   64'(0));
    check_output("rst.rx_ready",  64'(rx_ready),  64'(0));
    check_output("rst.stale_cnt", 64'(stale_cnt), 64'(0));
    rst = 1'b0; m_ptr = 0; m_stale = 0;
    #1;
    check_output("rst.rx_ready_rel", 64'(rx_ready), 64'(1));
  endtask

  // One full transaction; ends sampled inside the RESP cycle.
  task automatic run_txn(input logic [N-1:0] mask, input bit keep, input int stall,
                         input int d, input bit junk, input bit no_resp,
                         input logic [15:0] rdat, input string tag);
    int          g;
    logic        we;
    logic [15:0] a, w, exp_rd;
    logic        exp_err;
    flit_t       ef;
    bit          done;
    @(negedge clk);
    req_valid = mask; tx_ready = (stall == 0); rx_valid = 1'b0;
    #1;
    g = exp_grant(mask, m_ptr);
    check_output({tag, ".req_ready"}, 64'(req_ready), 64'(onehot(g)));
    check_output({tag, ".rsp_idle"},  64'(rsp_valid), 64'(0));
    m_ptr = (g + 1) % N;
    we = req_we[g]; a = req_addr[g*16+:16]; w = req_wdata[g*16+:16];
    ef = ref_flit(VC_REQ, we ? OP_WRITE : OP_READ_REQ, 4'd0, 4'd0, 4'd1, 4'd0,
                  {a, we ? w : 16'h0000});
    @(negedge clk);
    if (!keep) req_valid[g] = 1'b0;
    #1;
    check_output({tag, ".tx_valid"},  64'(tx_valid),  64'(1));
    check_output({tag, ".tx_flit"},   64'(tx_flit),   64'(ef));
    check_output({tag, ".no_regrant"}, 64'(req_ready), 64'(0));
    for (int s = 0; s < stall; s++) begin
      check_output({tag, ".stall_rsp"}, 64'(rsp_valid), 64'(0));
      @(negedge clk);
      if (s == stall - 1) tx_ready = 1'b1;
      #1;
      check_output({tag, ".hold_valid"}, 64'(tx_valid), 64'(1));
      check_output({tag, ".hold_flit"},  64'(tx_flit),  64'(ef));
    end
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    if (we) begin
      exp_rd = 16'h0000; exp_err = 1'b0;
    end else begin
      check_output({tag, ".tx_drop"}, 64'(tx_valid), 64'(0));
      exp_rd  = no_resp ? 16'hDEAD : rdat;
      exp_err = no_resp;
      done    = 1'b0;
      for (int k = 0; k < TO && !done; k++) begin
        if (!no_resp && k == d) begin
          rx_valid = 1'b1;
          rx_flit  = ref_flit(VC_RSP, OP_READ_RESP, 4'd1, 4'd0, 4'd0, 4'd0, {a, rdat});
        end else if (junk && k == 0) begin
          rx_valid = 1'b1;
          rx_flit  = ref_flit(VC_RSP, OP_READ_RESP, 4'd1, 4'd0, 4'd0, 4'd0, {a ^ 16'h0100, rdat});
          m_stale++;
        end
        check_output({tag, ".wait_rsp"}, 64'(rsp_valid), 64'(0));
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        done = no_resp ? (k == TO - 1) : (k == d);
      end
    end
    check_output({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(onehot(g)));
    check_output({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
    check_output({tag, ".rsp_err"},   64'(rsp_err),   64'(exp_err));
    check_output({tag, ".resp_nogrant"}, 64'(req_ready), 64'(0));
    check_output({tag, ".stale_cnt"}, 64'(stale_cnt), 64'(m_stale));
  endtask

  initial begin
    logic [N-1:0] mask;
    int           stall, d;
    bit           junk, no_resp;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_flit = '0;

    do_reset();

    // Posted write from requester 0.
    apply_stimulus(0, 1'b1, 16'h0010, 16'hBEEF);
    run_txn(4'b0001, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0, "t1_write");

    // Read from requester 1 answered after 5 cycles; data must hold afterwards.
    apply_stimulus(1, 1'b0, 16'hF000, 16'h1111);
    run_txn(4'b0010, 1'b0, 0, 5, 1'b0, 1'b0, 16'h434B, "t2_read");
    @(negedge clk); #1;
    check_output("t2.rdata_hold", 64'(rsp_rdata), 64'(16'h434B));
    check_output("t2.rsp_pulse",  64'(rsp_valid), 64'(0));

    // All four requesting continuously from reset.
    do_reset();
    for (int p = 0; p < N; p++) apply_stimulus(p, 1'b1, 16'(16'h0100 * p), 16'(16'hA000 + p));
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 1'b1, 0, 0, 1'b0, 1'b0, 16'h0, "t3_rr");

    // Timeout, then the late response counts as stale.
    do_reset();
    apply_stimulus(3, 1'b0, 16'h0A0A, 16'h0);
    run_txn(4'b1000, 1'b0, 0, 0, 1'b0, 1'b1, 16'h0, "t4_timeout");
    @(negedge clk);
    rx_valid = 1'b1;
    rx_flit  = ref_flit(VC_RSP, OP_READ_RESP, 4'd1, 4'd0, 4'd0, 4'd0, {16'h0A0A, 16'h7777});
    m_stale++;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    check_output("t4.late_stale", 64'(stale_cnt), 64'(m_stale));
    check_output("t4.late_norsp", 64'(rsp_valid), 64'(0));

    // Backpressure plus a wrong-address response during the wait.
    do_reset();
    apply_stimulus(2, 1'b0, 16'h5555, 16'h0);
    run_txn(4'b0100, 1'b0, 7, 6, 1'b1, 1'b0, 16'h9ABC, "t5_bp");

    // Reset while a read waits for its response.
    do_reset();
    apply_stimulus(2, 1'b0, 16'h1234, 16'h0);
    @(negedge clk);
    req_valid = 4'b0100; tx_ready = 1'b1;
    #1;
    check_output("t6.grant", 64'(req_ready), 64'(onehot(exp_grant(4'b0100, m_ptr))));
    m_ptr = (exp_grant(4'b0100, m_ptr) + 1) % N;
    @(negedge clk);
    req_valid = '0;
    #1;
    check_output("t6.tx_valid", 64'(tx_valid), 64'(1));
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    check_output("t6.waiting", 64'(tx_valid), 64'(0));
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check_output("t6.no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_flit  = ref_flit(VC_RSP, OP_READ_RESP, 4'd1, 4'd0, 4'd0, 4'd0, {16'h1234, 16'hBEAD});
    m_stale++;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    check_output("t6.drain_stale", 64'(stale_cnt), 64'(m_stale));
    for (int p = 0; p < N; p++) apply_stimulus(p, 1'b1, 16'(16'h2000 + p), 16'(16'h3000 + p));
    run_txn(4'b1111, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0, "t6_ptr0");

    // Random traffic.
    for (int t = 0; t < 24; t++) begin
      for (int p = 0; p < N; p++)
        apply_stimulus(p, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      mask    = 4'($urandom_range(1, 15));
      stall   = $urandom_range(0, 3);
      no_resp = ($urandom_range(0, 7) == 0);
      d       = $urandom_range(0, TO - 1);
      junk    = (d > 0) && ($urandom_range(0, 1) == 1);
      run_txn(mask, 1'b0, stall, d, junk, no_resp, 16'($urandom), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
